systolic_result_drain: RTL and testbench

- Reads the accumulator results out of one row of COLS processing elements once a matrix-multiply pass has finished.
- Snapshots all COLS signed fixed-point accumulators in a single cycle.
- Streams them out one lane per beat over a valid/ready interface, saturating each value from N bits down to OUT_W bits. The fractional point (Q) is unchanged.
- Sits between the PE array and the result buffer/writeback logic.

---
 rtl/tpu_pkg.sv | 30 +++
 rtl/sat_narrow.sv | 21 ++
 rtl/systolic_result_drain.sv | 94 +++++++++
 tb/tb_systolic_result_drain.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared types and helpers for the systolic array result path.
package tpu_pkg;

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  typedef struct packed {
    logic               sat;
    logic signed [63:0] val;
  } sat_res_t;

  // Clip a sign-extended value into the signed range of w bits (w <= 64).
  function automatic sat_res_t sat_clip(input logic signed [63:0] v, input int unsigned w);
    logic signed [63:0] mx, mn;
    sat_res_t r;
    mx = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn = -(64'sd1 <<< (w - 1));
    if (v > mx) begin
      r.sat = 1'b1;
      r.val = mx;
    end else if (v < mn) begin
      r.sat = 1'b1;
      r.val = mn;
    end else begin
      r.sat = 1'b0;
      r.val = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/sat_narrow.sv
// Combinational signed saturation from N bits down to OUT_W bits.
module sat_narrow
  import tpu_pkg::*;
#(
  parameter int N     = 32,
  parameter int OUT_W = 16
) (
  input  logic signed [N-1:0]     val_i,
  output logic signed [OUT_W-1:0] val_o,
  output logic                    sat_o
);

  sat_res_t r;
  logic     unused_hi;

  assign r         = sat_clip(64'(val_i), OUT_W);
  assign val_o     = r.val[OUT_W-1:0];
  assign sat_o     = r.sat;
  assign unused_hi = ^r.val[63:OUT_W];

endmodule

// File: rtl/systolic_result_drain.sv
// Snapshots one PE row's accumulators and streams them out one saturated lane per beat.
module systolic_result_drain
  import tpu_pkg::*;
#(
  parameter int N     = 32,
  parameter int Q     = 10,
  parameter int COLS  = 4,
  parameter int OUT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [COLS*N-1:0]       acc_in,
  output logic                    busy,
  output logic [OUT_W-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(COLS)-1:0] out_idx,
  output logic                    out_last,
  output logic                    out_sat,
  output logic                    sat_any,
  output logic                    done
);

  localparam int IDXW     = $clog2(COLS);
  localparam int unused_q = Q;  // fixed point carried through untouched

  state_t                  state_q;
  logic [COLS-1:0][N-1:0]  snap_q;
  logic [IDXW-1:0]         idx_q;
  logic                    vld_q, busy_q, done_q, sat_any_q;
  logic signed [OUT_W-1:0] lane_val;
  logic                    lane_sat;
  logic                    is_last;

  sat_narrow #(.N(N), .OUT_W(OUT_W)) u_sat (
    .val_i (snap_q[idx_q]),
    .val_o (lane_val),
    .sat_o (lane_sat)
  );

  assign is_last = (idx_q == IDXW'(COLS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      snap_q    <= '0;
      idx_q     <= '0;
      vld_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sat_any_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            snap_q    <= acc_in;
            idx_q     <= '0;
            sat_any_q <= 1'b0;
            vld_q     <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= STREAM;
          end
        end
        STREAM: begin
          // start is deliberately ignored here: no queueing, snapshot untouched
          if (vld_q && out_ready) begin
            if (lane_sat) sat_any_q <= 1'b1;
            if (is_last) begin
              vld_q   <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign out_valid = vld_q;
  assign out_data  = lane_val;
  assign out_idx   = idx_q;
  assign out_last  = vld_q & is_last;
  assign out_sat   = vld_q & lane_sat;
  assign sat_any   = sat_any_q;
  assign done      = done_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain: vector table of frames plus corner-case sequences.
module tb_systolic_result_drain;

  localparam int N = 32, Q = 10, COLS = 4, OUT_W = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [COLS*N-1:0] acc_in = '0;
  logic              busy, out_valid, out_last, out_sat, sat_any, done;
  logic              out_ready = 1'b1;
  logic [OUT_W-1:0]  out_data;
  logic [1:0]        out_idx;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  systolic_result_drain #(.N(N), .Q(Q), .COLS(COLS), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .acc_in(acc_in), .busy(busy),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_last(out_last), .out_sat(out_sat),
    .sat_any(sat_any), .done(done)
  );

  typedef struct {
    logic [3:0][31:0] lanes;
    logic [3:0][15:0] exp_data;
    logic [3:0]       exp_sat;
    logic             exp_any;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Runs one frame starting at a negedge; returns at the negedge where done should be high.
  task automatic run_frame(input vec_t v, input int stall_k, input int stall_n, input bit poke);
    acc_in = v.lanes;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (poke) acc_in = {4{32'd7}};
    chk("sat_any_cleared", 64'(sat_any), 64'd0);
    for (int k = 0; k < 4; k++) begin
      if (k == stall_k) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          chk("stall_valid", 64'(out_valid), 64'd1);
          chk("stall_data", 64'(out_data), 64'(v.exp_data[k]));
          chk("stall_idx", 64'(out_idx), 64'(k));
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
      chk("beat_valid", 64'(out_valid), 64'd1);
      chk("beat_busy", 64'(busy), 64'd1);
      chk("beat_idx", 64'(out_idx), 64'(k));
      chk("beat_data", 64'(out_data), 64'(v.exp_data[k]));
      chk("beat_sat", 64'(out_sat), 64'(v.exp_sat[k]));
      chk("beat_last", 64'(out_last), 64'(k == 3));
      chk("beat_nodone", 64'(done), 64'd0);
      start = poke && (k == 1);
      @(negedge clk);
      start = 1'b0;
    end
    chk("end_done", 64'(done), 64'd1);
    chk("end_valid", 64'(out_valid), 64'd0);
    chk("end_busy", 64'(busy), 64'd0);
    chk("end_sat_any", 64'(sat_any), 64'(v.exp_any));
  endtask

  vec_t vt[4];

  initial begin
    vt[0] = '{lanes: {32'hFFFF8000, 32'd32767, 32'hFFFFFFFB, 32'd100},
              exp_data: {16'h8000, 16'h7FFF, 16'hFFFB, 16'd100},
              exp_sat: 4'b0000, exp_any: 1'b0};
    vt[1] = '{lanes: {32'hFFFFFFFF, 32'd1024, 32'hFFFF63C0, 32'd40000},
              exp_data: {16'hFFFF, 16'd1024, 16'h8000, 16'h7FFF},
              exp_sat: 4'b0011, exp_any: 1'b1};
    vt[2] = '{lanes: {32'hFFFF7FFF, 32'd32768, 32'hFFFEFFFF, 32'd65536},
              exp_data: {16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF},
              exp_sat: 4'b1111, exp_any: 1'b1};
    vt[3] = '{lanes: {32'd12345, 32'hFFFF8001, 32'd1, 32'd0},
              exp_data: {16'd12345, 16'h8001, 16'd1, 16'd0},
              exp_sat: 4'b0000, exp_any: 1'b0};

    // reset state
    #2;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_idx", 64'(out_idx), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sat_any", 64'(sat_any), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      run_frame(vt[i], -1, 0, 1'b0);
      @(negedge clk);
      chk("post_done_low", 64'(done), 64'd0);
      chk("post_sat_any_held", 64'(sat_any), 64'(vt[i].exp_any));
    end

    // backpressure on beat 1
    run_frame(vt[0], 1, 3, 1'b0);
    @(negedge clk);

    // ignored start mid-frame, acc_in changed after capture
    run_frame(vt[0], -1, 0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("no_second_frame", 64'(out_valid), 64'd0);
      chk("no_second_busy", 64'(busy), 64'd0);
    end

    // back-to-back: start in the done cycle
    run_frame(vt[1], -1, 0, 1'b0);
    run_frame(vt[0], -1, 0, 1'b0);
    @(negedge clk);

    // reset mid-stream during beat 2
    acc_in = vt[1].lanes;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_idx", 64'(out_idx), 64'd2);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_data", 64'(out_data), 64'd0);
    chk("arst_idx", 64'(out_idx), 64'd0);
    chk("arst_last", 64'(out_last), 64'd0);
    chk("arst_sat", 64'(out_sat), 64'd0);
    chk("arst_sat_any", 64'(sat_any), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_no_done", 64'(done), 64'd0);
      chk("rst_no_valid", 64'(out_valid), 64'd0);
    end
    run_frame(vt[3], -1, 0, 1'b0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
